jk_bank_sequencer: RTL and testbench
====================================

Name: jk_bank_sequencer

Overview:
Round-robin sequencer that shares one bank of WIDTH JK storage cells between NUM_REQ requesters. Each requester posts a JK command (hold/reset/set/toggle), a bit mask and a repeat count. The winner's command is applied to the masked bits for the requested number of clocks, then the winner receives a one-cycle acknowledge. The block sits between control agents and the JK register bank and is the only writer of that bank.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, number of JK cells in the bank
CNT_W, 4, width of each repeat-count field

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  request, one bit per requester
cmd  in  2*NUM_REQ  per-requester {j,k}: 00 hold, 01 reset, 10 set, 11 toggle
mask  in  WIDTH*NUM_REQ  per-requester bit-select; 1 = cell driven by cmd
count  in  CNT_W*NUM_REQ  per-requester repeat count; 0 treated as 1
ack  out  NUM_REQ  one-hot completion pulse to the granted requester
busy  out  1  high whenever state != IDLE
q  out  WIDTH  JK bank contents

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high. No asynchronous paths.
- Reset (any state, takes priority):
  - q <= 0, state <= IDLE, ack <= 0.
  - Round-robin pointer <= NUM_REQ-1, so requester 0 has first priority.
  - Latched command registers <= 0.
- States: IDLE, RUN, ACK.
- IDLE:
  - On an edge with any req bit set, select the first set bit searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - Latch that requester's cmd, mask and count (0 becomes 1) plus its index. Go to RUN.
  - With no requests, stay in IDLE.
  - q never changes while in IDLE.
- RUN:
  - On every edge, each cell with latched mask=1 performs the JK action of the latched cmd.
  - Cells with mask=0 hold.
  - The remaining-count register decrements on each of these edges.
  - On the edge that performs the final application, go to ACK.
  - Exactly max(count,1) applications occur.
  - Inputs cmd/mask/count/req are ignored in RUN.
- ACK:
  - ack[idx]=1 for exactly this one cycle; all other ack bits are 0.
  - On the next edge: ptr <= idx, go to IDLE.
  - A requester that keeps req high is re-eligible in IDLE, behind the other pending requesters.
- Timing: a request sampled at edge E0 produces q updates at E1..En, ack high in the cycle after En, and IDLE again after E(n+1). Occupancy is n+2 cycles per grant.
- Outputs: ack and busy are Moore outputs decoded from registered state; there is no combinational path from req to ack.
- Boundary cases:
  - cmd=00 still consumes count cycles and still acks.
  - mask=0 acks with q unchanged.
  - Count of all-ones gives 2^CNT_W-1 applications.
  - Reset during RUN or ACK aborts the operation: no ack, q=0.

Decomposition:
- Package jk_seq_pkg holds:
  - command localparams CMD_HOLD=2'b00, CMD_RST=2'b01, CMD_SET=2'b10, CMD_TGL=2'b11;
  - the state encoding (IDLE, RUN, ACK).
- Sub-module jk_cell: one-bit JK element with synchronous active-high reset and an enable, instantiated WIDTH times in a generate loop. Per cell, j/k = mask ? cmd : 2'b00.
- Arbiter, FSM and counter stay in the top module.

Test Plan:
1. Reset held 2 cycles, req=0 -> q=8'h00, busy=0, ack=4'b0000; hold reset during activity -> same values one edge later.
2. req[0], cmd=10, mask=8'h0F, count=1 -> q=8'h0F one edge after sampling; ack=4'b0001 for one cycle; busy high 2 cycles.
3. From q=8'h0F: req[2], cmd=11, mask=8'hF0, count=3 -> q sequence 8'hFF, 8'h0F, 8'hFF; then ack=4'b0100.
4. All four req held high, count=1, cmd=00 -> acks arrive in order 0001, 0010, 0100, 1000, 0001, each grant 3 cycles apart; q unchanged.
5. req[1], cmd=11, mask=8'hFF, count=5, reset asserted on the 2nd RUN edge -> q=8'h00 next edge, no ack; next grant goes to req[0] when both req[0] and req[1] are pending.
6. From q=8'hFF: req[3], cmd=01, mask=8'h3C, count=0 -> exactly one application, q=8'hC3; ack=4'b1000.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared command codes and FSM encoding for the JK bank sequencer
package jk_seq_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_RST  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TGL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_ACK  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - one-bit JK storage element with enable and synchronous reset
module jk_cell
  import jk_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else if (i_en) begin
      case ({i_j, i_k})
        CMD_RST: r_q <= 1'b0;
        CMD_SET: r_q <= 1'b1;
        CMD_TGL: r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - round-robin sequencer sharing one JK bank among requesters
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [2*NUM_REQ-1:0]       cmd,
  input  logic [WIDTH*NUM_REQ-1:0]   mask,
  input  logic [CNT_W*NUM_REQ-1:0]   count,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       busy,
  output logic [WIDTH-1:0]           q
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  seq_state_t         r_state;
  seq_state_t         w_next;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [1:0]         r_cmd;
  logic [WIDTH-1:0]   r_mask;
  logic [CNT_W-1:0]   r_cnt;

  logic [1:0]         w_cmd_arr   [NUM_REQ];
  logic [WIDTH-1:0]   w_mask_arr  [NUM_REQ];
  logic [CNT_W-1:0]   w_count_arr [NUM_REQ];
  logic               w_found;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [IDX_W-1:0]   w_cand;
  logic [CNT_W-1:0]   w_grant_cnt;
  logic               w_last;
  logic               w_run;
  logic [WIDTH-1:0]   w_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cmd_arr[i]   = cmd[2*i +: 2];
      w_mask_arr[i]  = mask[WIDTH*i +: WIDTH];
      w_count_arr[i] = count[CNT_W*i +: CNT_W];
    end
  end

  // Search starts one past the last winner so a granted requester goes to the back of the line.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  assign w_grant_cnt = (w_count_arr[w_grant_idx] == '0) ? CNT_W'(1) : w_count_arr[w_grant_idx];
  assign w_last      = (r_cnt == CNT_W'(1));
  assign w_run       = (r_state == ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_next = ST_RUN;
      ST_RUN:  if (w_last)  w_next = ST_ACK;
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ack  = '0;
    busy = (r_state != ST_IDLE);
    if (r_state == ST_ACK) begin
      ack[r_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr  <= IDX_W'(NUM_REQ - 1);
      r_idx  <= '0;
      r_cmd  <= CMD_HOLD;
      r_mask <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_idx  <= w_grant_idx;
            r_cmd  <= w_cmd_arr[w_grant_idx];
            r_mask <= w_mask_arr[w_grant_idx];
            r_cnt  <= w_grant_cnt;
          end
        end
        ST_RUN:  r_cnt <= r_cnt - CNT_W'(1);
        ST_ACK:  r_ptr <= r_idx;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_run),
      .i_j   (r_mask[g] & r_cmd[1]),
      .i_k   (r_mask[g] & r_cmd[0]),
      .o_q   (w_q[g])
    );
  end

  assign q = w_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb/tb_jk_bank_sequencer.sv - directed self-checking bench for jk_bank_sequencer
module tb_jk_bank_sequencer;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  cmd;
  logic [31:0] mask;
  logic [15:0] count;
  logic [3:0]  ack;
  logic        busy;
  logic [7:0]  q;

  int checks;
  int failures;

  jk_bank_sequencer #(.NUM_REQ(4), .WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .cmd   (cmd),
    .mask  (mask),
    .count (count),
    .ack   (ack),
    .busy  (busy),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] eq, input logic eb, input logic [3:0] ea);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".ack"}, 32'(ack), 32'(ea));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    req   = '0;
    cmd   = '0;
    mask  = '0;
    count = '0;

    // 1: reset, then reset held while a request is posted
    tick();
    tick();
    check_all("rst", 8'h00, 1'b0, 4'b0000);
    req = 4'b0001; cmd[1:0] = 2'b10; mask[7:0] = 8'hFF; count[3:0] = 4'd1;
    tick();
    check_all("rst_act", 8'h00, 1'b0, 4'b0000);
    reset = 1'b0;

    // 2: set low nibble, count=1
    req = 4'b0001; cmd[1:0] = 2'b10; mask[7:0] = 8'h0F; count[3:0] = 4'd1;
    tick();
    check_all("t2_e0", 8'h00, 1'b1, 4'b0000);
    req = '0;
    tick();
    check_all("t2_e1", 8'h0F, 1'b1, 4'b0001);
    tick();
    check_all("t2_e2", 8'h0F, 1'b0, 4'b0000);

    // 3: toggle high nibble 3 times, requester 2
    req = 4'b0100; cmd[5:4] = 2'b11; mask[23:16] = 8'hF0; count[11:8] = 4'd3;
    tick();
    check_all("t3_e0", 8'h0F, 1'b1, 4'b0000);
    req = '0;
    tick();
    check_all("t3_e1", 8'hFF, 1'b1, 4'b0000);
    tick();
    check_all("t3_e2", 8'h0F, 1'b1, 4'b0000);
    tick();
    check_all("t3_e3", 8'hFF, 1'b1, 4'b0100);
    tick();
    check_all("t3_e4", 8'hFF, 1'b0, 4'b0000);

    // 4: all requesters, hold command; reset first so requester 0 leads
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all("t4_rst", 8'h00, 1'b0, 4'b0000);
    req = 4'b1111; cmd = 8'h00; mask = 32'hFFFF_FFFF; count = 16'h1111;
    for (int k = 1; k <= 15; k++) begin
      logic [3:0] exp_ack;
      logic [3:0] one_hot;
      one_hot = 4'b0001;
      exp_ack = ((k % 3) == 2) ? (one_hot << ((k / 3) % 4)) : 4'b0000;
      tick();
      if (k == 14) req = '0;
      check_all($sformatf("t4_k%0d", k), 8'h00, ((k % 3) != 0), exp_ack);
    end

    // 5: toggle from requester 1 aborted by reset on second RUN edge
    req = 4'b0010; cmd[3:2] = 2'b11; mask[15:8] = 8'hFF; count[7:4] = 4'd5;
    tick();
    check_all("t5_e0", 8'h00, 1'b1, 4'b0000);
    req = '0;
    tick();
    check_all("t5_e1", 8'hFF, 1'b1, 4'b0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all("t5_abort", 8'h00, 1'b0, 4'b0000);
    req = 4'b0011; cmd[1:0] = 2'b10; mask[7:0] = 8'hFF; count[3:0] = 4'd1;
    tick();
    check_all("t5_g0", 8'h00, 1'b1, 4'b0000);
    req = '0;
    tick();
    check_all("t5_g1", 8'hFF, 1'b1, 4'b0001);
    tick();
    check_all("t5_g2", 8'hFF, 1'b0, 4'b0000);

    // 6: count=0 means one application, reset of middle bits
    req = 4'b1000; cmd[7:6] = 2'b01; mask[31:24] = 8'h3C; count[15:12] = 4'd0;
    tick();
    check_all("t6_e0", 8'hFF, 1'b1, 4'b0000);
    req = '0;
    tick();
    check_all("t6_e1", 8'hC3, 1'b1, 4'b1000);
    tick();
    check_all("t6_e2", 8'hC3, 1'b0, 4'b0000);
    tick();
    check_all("t6_idle", 8'hC3, 1'b0, 4'b0000);

    // 7: all-ones count gives 15 toggles of bit 0 from requester 2
    req = 4'b0100; cmd[5:4] = 2'b11; mask[23:16] = 8'h01; count[11:8] = 4'hF;
    tick();
    req = '0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("t7_ack_k%0d", k), 32'(ack), (k == 15) ? 32'h4 : 32'h0);
    end
    check("t7_q", 32'(q), 32'hC2);
    tick();
    check_all("t7_done", 8'hC2, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
